reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter PHY_DLY, default 24, meaning clk cycles from PLL lock to PHY reset release (1 us at 24 MHz).
REQ-002 SHALL have parameter CORE_DLY, default 240, meaning clk cycles from PHY reset release to core reset release.
REQ-003 SHALL have parameter ATTACH_DLY, default 24000, meaning clk cycles from core reset release to D+ pull-up enable (1 ms).
REQ-004 SHALL have port clk  input  1  system clock, 24 MHz.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset, already synchronized to clk by the upstream key synchronizer.
REQ-006 SHALL have port pll_locked  input  1  PLL lock indication, synchronous to clk.
REQ-007 SHALL have port phy_reset  output  1  USB PHY reset, active-high.
REQ-008 SHALL have port core_reset  output  1  USB device core reset, active-high.
REQ-009 SHALL have port pullup_en  output  1  D+ 1.5 kOhm pull-up enable (bus attach).
REQ-010 SHALL have port ready  output  1  sequence complete; high only in state RUN.

Function
REQ-011 SHALL implement states HOLD, WAIT_LOCK, PHY_WAIT, CORE_WAIT, ATTACH_WAIT, RUN; all outputs registered.
REQ-012 SHALL use a single delay counter; width = $clog2(max(PHY_DLY, CORE_DLY, ATTACH_DLY)+1); cleared on every state entry; no wrap-around is reachable.
REQ-013 SHALL leave HOLD for WAIT_LOCK on the first edge with reset=0.
REQ-014 SHALL leave WAIT_LOCK for PHY_WAIT on the edge sampling pll_locked=1 (edge L).
REQ-015 SHALL deassert phy_reset on edge L+PHY_DLY and enter CORE_WAIT.
REQ-016 SHALL deassert core_reset CORE_DLY edges after phy_reset falls and enter ATTACH_WAIT.
REQ-017 SHALL assert pullup_en and ready together, ATTACH_DLY edges after core_reset falls, and enter RUN.
REQ-018 SHALL, on pll_locked=0 sampled in PHY_WAIT, CORE_WAIT, ATTACH_WAIT or RUN, return next edge to WAIT_LOCK with phy_reset=1, core_reset=1, pullup_en=0, ready=0, and the counter cleared.
REQ-019 SHALL, when reset=1 and pll_locked=0 occur on the same edge, give priority to reset (enter HOLD).
REQ-020 SHALL guarantee the ordering phy_reset release <= core_reset release <= pullup_en assert, with no glitches on any output.
REQ-021 SHALL support parameter values >= 1 only; a value of 1 gives a one-cycle step.

Reset
REQ-022 SHALL, on any edge with reset=1 in any state, enter HOLD with phy_reset=1, core_reset=1, pullup_en=0, ready=0, and counter=0.
REQ-023 SHALL restart the full sequence from WAIT_LOCK after reset is released mid-sequence; no partial state is retained.

Configuration
REQ-024 SHALL, with macro RESET_SEQ_SOFT_DETACH_EN defined, add port detach (input, 1 bit); detach=1 in RUN drops pullup_en and ready on the next edge, enters state DETACHED, and keeps phy_reset=0 and core_reset=0.
REQ-025 SHALL, with RESET_SEQ_SOFT_DETACH_EN defined, leave DETACHED on detach=0, enter ATTACH_WAIT, and reassert pullup_en and ready after ATTACH_DLY edges; pll_locked=0 or reset=1 in DETACHED follows REQ-018 or REQ-022.
REQ-026 SHALL, without RESET_SEQ_SOFT_DETACH_EN, have neither the detach port nor the DETACHED state.

Verification (bench parameters PHY_DLY=4, CORE_DLY=8, ATTACH_DLY=16)
REQ-027 SHALL cover: reset=1 for 3 cycles, then pll_locked rising at edge L=10 -> phy_reset falls at edge 14, core_reset at 22, pullup_en and ready rise at 38.
REQ-028 SHALL cover: pll_locked held 0 for 100 cycles after reset -> all outputs stay at reset values.
REQ-029 SHALL cover: pll_locked drops at edge 18 (CORE_WAIT) -> phy_reset=1 at edge 19; relock at edge 25 -> phy_reset falls at edge 29.
REQ-030 SHALL cover: reset=1 asserted in RUN together with pll_locked=0 -> HOLD next edge, all outputs at reset values; full sequence replays after release.
REQ-031 SHALL cover: with RESET_SEQ_SOFT_DETACH_EN, detach=1 at edge 50 in RUN -> pullup_en=0 at edge 51 while core_reset stays 0; detach=0 at edge 60 -> pullup_en=1 at edge 76.

Source files
------------

// File: rtl/reset_seq.sv
// USB power-up reset sequencer: PLL lock -> PHY reset release -> core reset release -> D+ pull-up.
// Optional soft detach (DETACHED state, detach port) is enabled by defining RESET_SEQ_SOFT_DETACH_EN.
//
// state       | meaning
// HOLD        | upstream reset asserted, everything held in reset
// WAIT_LOCK   | waiting for pll_locked
// PHY_WAIT    | PLL locked, counting PHY_DLY before releasing phy_reset
// CORE_WAIT   | PHY running, counting CORE_DLY before releasing core_reset
// ATTACH_WAIT | core running, counting ATTACH_DLY before enabling the pull-up
// RUN         | attached to the bus, ready=1
// DETACHED    | software detach: pull-up off, PHY and core stay out of reset
module reset_seq #(
   parameter int PHY_DLY    = 24,
   parameter int CORE_DLY   = 240,
   parameter int ATTACH_DLY = 24000
) (
   input  logic clk,
   input  logic reset,
   input  logic pll_locked,
`ifdef RESET_SEQ_SOFT_DETACH_EN
   input  logic detach,
`endif
   output logic phy_reset,
   output logic core_reset,
   output logic pullup_en,
   output logic ready
);

   localparam int MAX_PC  = (PHY_DLY > CORE_DLY) ? PHY_DLY : CORE_DLY;
   localparam int MAX_DLY = (MAX_PC > ATTACH_DLY) ? MAX_PC : ATTACH_DLY;
   localparam int CW      = $clog2(MAX_DLY + 1);

   // Counter is cleared on state entry, so the last cycle of a wait sees DLY-1.
   localparam logic [CW-1:0] PHY_TC    = CW'(PHY_DLY - 1);
   localparam logic [CW-1:0] CORE_TC   = CW'(CORE_DLY - 1);
   localparam logic [CW-1:0] ATTACH_TC = CW'(ATTACH_DLY - 1);

   typedef enum logic [2:0] {
      HOLD        = 3'd0,
      WAIT_LOCK   = 3'd1,
      PHY_WAIT    = 3'd2,
      CORE_WAIT   = 3'd3,
      ATTACH_WAIT = 3'd4,
      RUN         = 3'd5
`ifdef RESET_SEQ_SOFT_DETACH_EN
      , DETACHED  = 3'd6
`endif
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_phy_reset;
   logic            r_core_reset;
   logic            r_pullup_en;
   logic            r_ready;
   logic            w_phy_reset_nxt;
   logic            w_core_reset_nxt;
   logic            w_pullup_en_nxt;
   logic            w_ready_nxt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         HOLD:        w_state_nxt = WAIT_LOCK;
         WAIT_LOCK:   if (pll_locked) w_state_nxt = PHY_WAIT;
         PHY_WAIT:    if (!pll_locked) w_state_nxt = WAIT_LOCK;
                      else if (r_cnt == PHY_TC) w_state_nxt = CORE_WAIT;
         CORE_WAIT:   if (!pll_locked) w_state_nxt = WAIT_LOCK;
                      else if (r_cnt == CORE_TC) w_state_nxt = ATTACH_WAIT;
         ATTACH_WAIT: if (!pll_locked) w_state_nxt = WAIT_LOCK;
                      else if (r_cnt == ATTACH_TC) w_state_nxt = RUN;
         RUN: begin
            if (!pll_locked) w_state_nxt = WAIT_LOCK;
`ifdef RESET_SEQ_SOFT_DETACH_EN
            else if (detach) w_state_nxt = DETACHED;
`endif
         end
`ifdef RESET_SEQ_SOFT_DETACH_EN
         DETACHED:    if (!pll_locked) w_state_nxt = WAIT_LOCK;
                      else if (!detach) w_state_nxt = ATTACH_WAIT;
`endif
         default:     w_state_nxt = HOLD;
      endcase
      if (reset) w_state_nxt = HOLD;

      w_cnt_nxt = r_cnt;
      if (w_state_nxt != r_state)
         w_cnt_nxt = '0;
      else if ((r_state == PHY_WAIT) || (r_state == CORE_WAIT) || (r_state == ATTACH_WAIT))
         w_cnt_nxt = r_cnt + CW'(1);

      // Outputs are decoded from the next state so they switch on the same edge as the state.
      w_phy_reset_nxt  = 1'b1;
      w_core_reset_nxt = 1'b1;
      w_pullup_en_nxt  = 1'b0;
      w_ready_nxt      = 1'b0;
      case (w_state_nxt)
         CORE_WAIT: begin
            w_phy_reset_nxt  = 1'b0;
         end
         ATTACH_WAIT: begin
            w_phy_reset_nxt  = 1'b0;
            w_core_reset_nxt = 1'b0;
         end
         RUN: begin
            w_phy_reset_nxt  = 1'b0;
            w_core_reset_nxt = 1'b0;
            w_pullup_en_nxt  = 1'b1;
            w_ready_nxt      = 1'b1;
         end
`ifdef RESET_SEQ_SOFT_DETACH_EN
         DETACHED: begin
            w_phy_reset_nxt  = 1'b0;
            w_core_reset_nxt = 1'b0;
         end
`endif
         default: begin
            w_phy_reset_nxt  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= HOLD;
         r_cnt        <= '0;
         r_phy_reset  <= 1'b1;
         r_core_reset <= 1'b1;
         r_pullup_en  <= 1'b0;
         r_ready      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_phy_reset  <= w_phy_reset_nxt;
         r_core_reset <= w_core_reset_nxt;
         r_pullup_en  <= w_pullup_en_nxt;
         r_ready      <= w_ready_nxt;
      end
   end

   assign phy_reset  = r_phy_reset;
   assign core_reset = r_core_reset;
   assign pullup_en  = r_pullup_en;
   assign ready      = r_ready;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq with PHY_DLY=4, CORE_DLY=8, ATTACH_DLY=16.
// Define RESET_SEQ_SOFT_DETACH_EN for both files to exercise the soft-detach feature.
module tb_reset_seq;
   localparam int P = 4;
   localparam int C = 8;
   localparam int A = 16;
`ifdef RESET_SEQ_SOFT_DETACH_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic pll_locked;
   logic detach;
   logic phy_reset;
   logic core_reset;
   logic pullup_en;
   logic ready;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   logic [3:0] obs [0:127];

   // Reference model: timestamps of lock start and attach start, outputs derived from elapsed edges.
   int m_e = 0;
   int m_start = -1;
   int m_att = 0;
   bit m_hold = 1'b1;
   bit m_det = 1'b0;
   logic e_phy = 1'b1;
   logic e_core = 1'b1;
   logic e_pull = 1'b0;

   always #5 clk = ~clk;

   reset_seq #(.PHY_DLY(P), .CORE_DLY(C), .ATTACH_DLY(A)) dut (
      .clk(clk),
      .reset(reset),
      .pll_locked(pll_locked),
`ifdef RESET_SEQ_SOFT_DETACH_EN
      .detach(detach),
`endif
      .phy_reset(phy_reset),
      .core_reset(core_reset),
      .pullup_en(pullup_en),
      .ready(ready)
   );

   task automatic model_step(input logic r, input logic p, input logic d);
      m_e++;
      if (r) begin
         m_hold = 1'b1; m_start = -1; m_det = 1'b0;
      end else if (m_hold) begin
         m_hold = 1'b0;
      end else if (m_start < 0) begin
         if (p) begin m_start = m_e; m_att = m_e + P + C; end
      end else if (!p) begin
         m_start = -1; m_det = 1'b0;
      end else if (FEAT && m_det) begin
         if (!d) begin m_det = 1'b0; m_att = m_e; end
      end else if (FEAT && e_pull && d) begin
         m_det = 1'b1;
      end
      e_phy  = !(m_start >= 0 && (m_e - m_start) >= P);
      e_core = !(m_start >= 0 && (m_e - m_start) >= P + C);
      e_pull = (m_start >= 0) && !m_det && ((m_e - m_att) >= A);
   endtask

   task automatic tick(input logic r, input logic p, input logic d);
      reset = r; pll_locked = p; detach = d;
      @(posedge clk);
      edge_n++;
      model_step(r, p, d);
      #1;
      if (edge_n < 128) obs[edge_n] = {phy_reset, core_reset, pullup_en, ready};
   endtask

   task automatic test_reset();
      edge_n = 0;
      for (int e = 1; e <= 3; e++) begin
         tick(1'b1, 1'b1, 1'b0);
         checks++;
         if ({phy_reset, core_reset, pullup_en, ready} !== 4'b1100) begin
            errors++;
            $display("FAIL reset edge %0d got %b exp 1100", edge_n, {phy_reset, core_reset, pullup_en, ready});
         end
      end
   endtask

   task automatic test_nominal();
      edge_n = 0;
      for (int e = 1; e <= 45; e++) begin
         tick(e <= 3, e >= 10, 1'b0);
         checks++;
         if ({phy_reset, core_reset, pullup_en, ready} !== {e_phy, e_core, e_pull, e_pull}) begin
            errors++;
            $display("FAIL nominal_model edge %0d got %b exp %b", edge_n,
                     {phy_reset, core_reset, pullup_en, ready}, {e_phy, e_core, e_pull, e_pull});
         end
      end
      checks++;
      if (obs[13][3] !== 1'b1 || obs[14][3] !== 1'b0) begin
         errors++;
         $display("FAIL nominal_phy_fall got e13=%b e14=%b exp 1 0", obs[13][3], obs[14][3]);
      end
      checks++;
      if (obs[21][2] !== 1'b1 || obs[22][2] !== 1'b0) begin
         errors++;
         $display("FAIL nominal_core_fall got e21=%b e22=%b exp 1 0", obs[21][2], obs[22][2]);
      end
      checks++;
      if (obs[37][1:0] !== 2'b00 || obs[38][1:0] !== 2'b11) begin
         errors++;
         $display("FAIL nominal_attach got e37=%b e38=%b exp 00 11", obs[37][1:0], obs[38][1:0]);
      end
   endtask

   task automatic test_no_lock();
      edge_n = 0;
      for (int e = 1; e <= 103; e++) begin
         tick(e <= 3, 1'b0, 1'b0);
         checks++;
         if ({phy_reset, core_reset, pullup_en, ready} !== 4'b1100) begin
            errors++;
            $display("FAIL no_lock edge %0d got %b exp 1100", edge_n, {phy_reset, core_reset, pullup_en, ready});
         end
      end
   endtask

   task automatic test_lock_drop();
      edge_n = 0;
      for (int e = 1; e <= 40; e++) begin
         tick(e <= 3, (e >= 10 && e <= 18) || e >= 25, 1'b0);
         checks++;
         if ({phy_reset, core_reset, pullup_en, ready} !== {e_phy, e_core, e_pull, e_pull}) begin
            errors++;
            $display("FAIL drop_model edge %0d got %b exp %b", edge_n,
                     {phy_reset, core_reset, pullup_en, ready}, {e_phy, e_core, e_pull, e_pull});
         end
      end
      checks++;
      if ({obs[18][3], obs[19][3], obs[28][3], obs[29][3]} !== 4'b0110) begin
         errors++;
         $display("FAIL drop_phy got e18/19/28/29=%b exp 0110",
                  {obs[18][3], obs[19][3], obs[28][3], obs[29][3]});
      end
      checks++;
      if ({obs[19][2:0], obs[29][2:0]} !== 6'b100100) begin
         errors++;
         $display("FAIL drop_others got e19=%b e29=%b exp 100 100", obs[19][2:0], obs[29][2:0]);
      end
   endtask

   task automatic test_reset_in_run();
      edge_n = 0;
      for (int e = 1; e <= 75; e++) begin
         if (e == 41) tick(1'b1, 1'b0, 1'b0);
         else         tick(e <= 3, e >= 10 && e != 41, 1'b0);
         checks++;
         if ({phy_reset, core_reset, pullup_en, ready} !== {e_phy, e_core, e_pull, e_pull}) begin
            errors++;
            $display("FAIL rir_model edge %0d got %b exp %b", edge_n,
                     {phy_reset, core_reset, pullup_en, ready}, {e_phy, e_core, e_pull, e_pull});
         end
      end
      checks++;
      if (obs[40] !== 4'b0011 || obs[41] !== 4'b1100) begin
         errors++;
         $display("FAIL rir_hold got e40=%b e41=%b exp 0011 1100", obs[40], obs[41]);
      end
      checks++;
      if (obs[46][3] !== 1'b1 || obs[47][3] !== 1'b0 || obs[54][2] !== 1'b1 || obs[55][2] !== 1'b0) begin
         errors++;
         $display("FAIL rir_replay_resets got e46=%b e47=%b e54=%b e55=%b exp 1 0 1 0",
                  obs[46][3], obs[47][3], obs[54][2], obs[55][2]);
      end
      checks++;
      if (obs[70][1:0] !== 2'b00 || obs[71][1:0] !== 2'b11) begin
         errors++;
         $display("FAIL rir_replay_attach got e70=%b e71=%b exp 00 11", obs[70][1:0], obs[71][1:0]);
      end
   endtask

`ifdef RESET_SEQ_SOFT_DETACH_EN
   task automatic test_detach();
      edge_n = 0;
      for (int e = 1; e <= 80; e++) begin
         tick(e <= 3, e >= 10, e >= 51 && e <= 59);
         checks++;
         if ({phy_reset, core_reset, pullup_en, ready} !== {e_phy, e_core, e_pull, e_pull}) begin
            errors++;
            $display("FAIL detach_model edge %0d got %b exp %b", edge_n,
                     {phy_reset, core_reset, pullup_en, ready}, {e_phy, e_core, e_pull, e_pull});
         end
      end
      checks++;
      if (obs[50] !== 4'b0011 || obs[51] !== 4'b0000 || obs[75] !== 4'b0000 || obs[76] !== 4'b0011) begin
         errors++;
         $display("FAIL detach_points got e50=%b e51=%b e75=%b e76=%b exp 0011 0000 0000 0011",
                  obs[50], obs[51], obs[75], obs[76]);
      end
   endtask
`endif

   task automatic test_random();
      logic p;
      logic d;
      logic r;
      p = 1'b0;
      d = 1'b0;
      edge_n = 0;
      tick(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 119) == 0) p = ~p;
         if ($urandom_range(0, 59) == 0) d = ~d;
         tick(r, p, d);
         checks++;
         if ({phy_reset, core_reset, pullup_en, ready} !== {e_phy, e_core, e_pull, e_pull}) begin
            errors++;
            $display("FAIL random edge %0d got %b exp %b", edge_n,
                     {phy_reset, core_reset, pullup_en, ready}, {e_phy, e_core, e_pull, e_pull});
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      pll_locked = 1'b0;
      detach = 1'b0;
      test_reset();
      test_nominal();
      test_no_lock();
      test_lock_drop();
      test_reset_in_run();
`ifdef RESET_SEQ_SOFT_DETACH_EN
      test_detach();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
